// File: rtl/key_event_decoder.sv
// key_event_decoder
//
// Turns the periodic press strobe coming from the key debouncer into
// user-level events: single click, double click, long press and (optionally)
// auto-repeat. A press is considered released once no strobe has been seen
// for GAP_CYCLES cycles.
//
// Ports:
//   clk_i          in   clock
//   rst_i          in   synchronous, active-high reset
//   press_stb_i    in   debounced press strobe (repeats while key held)
//   click_o        out  one-cycle single-click pulse
//   double_click_o out  one-cycle double-click pulse
//   long_press_o   out  one-cycle pulse when the long-press threshold is hit
//   repeat_o       out  one-cycle auto-repeat pulse (0 unless repeat built in)
//   held_o         out  level, high while a press is in progress
//
// Build option:
//   KEY_EVENT_REPEAT_EN  when defined, LONG emits repeat_o every REPEAT_STB
//                        strobes; when undefined repeat_o is tied low.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | no key activity
// PRESS1 | first press in progress, counting strobes toward long press
// WAIT2  | first press released, double-click window running
// PRESS2 | second press in progress, double click on its release
// LONG   | long press reached, waiting for release (and auto-repeat)

module key_event_decoder #(
    parameter int GAP_CYCLES        = 64,
    parameter int DBL_WINDOW_CYCLES = 2048,
    parameter int LONG_STB          = 128,
    parameter int REPEAT_STB        = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic press_stb_i,
    output logic click_o,
    output logic double_click_o,
    output logic long_press_o,
    output logic repeat_o,
    output logic held_o
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int STB_W = $clog2(LONG_STB + 1);
    localparam int WIN_W = $clog2(DBL_WINDOW_CYCLES + 1);

    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_REL  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_MAX  = STB_W'(LONG_STB);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(DBL_WINDOW_CYCLES - 1);

    // Elaboration-time guard against degenerate parameter sets.
    generate
        if (GAP_CYCLES < 1 || DBL_WINDOW_CYCLES < 1 || LONG_STB < 1 || REPEAT_STB < 1) begin : g_param_check
            $error("key_event_decoder: all cycle/strobe parameters must be >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRESS1 = 3'd1,
        S_WAIT2  = 3'd2,
        S_PRESS2 = 3'd3,
        S_LONG   = 3'd4
    } state_t;

    state_t           r_state;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [STB_W-1:0] r_stb_cnt;
    logic [WIN_W-1:0] r_win_cnt;
    logic             r_click;
    logic             r_double;
    logic             r_long;
    logic             r_held;

    logic             w_release;
    logic [STB_W-1:0] w_stb_next;
    logic             w_long_hit;

    // A strobe in the same cycle always cancels the release.
    assign w_release  = !press_stb_i && (r_gap_cnt == GAP_REL);

    // Saturating next strobe count; saturation also makes LONG_STB=1 fire on
    // the second strobe, since IDLE->PRESS1 already loads a count of 1.
    assign w_stb_next = (r_stb_cnt == STB_MAX) ? STB_MAX : (r_stb_cnt + 1'b1);
    assign w_long_hit = (w_stb_next == STB_MAX);

`ifdef KEY_EVENT_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_STB + 1);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_STB);

    logic [REP_W-1:0] r_rep_cnt;
    logic             r_repeat;
    logic [REP_W-1:0] w_rep_next;

    assign w_rep_next = r_rep_cnt + 1'b1;
    assign repeat_o   = r_repeat;
`else
    assign repeat_o   = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_gap_cnt <= '0;
            r_stb_cnt <= '0;
            r_win_cnt <= '0;
            r_click   <= 1'b0;
            r_double  <= 1'b0;
            r_long    <= 1'b0;
            r_held    <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
            r_rep_cnt <= '0;
            r_repeat  <= 1'b0;
`endif
        end else begin
            r_click  <= 1'b0;
            r_double <= 1'b0;
            r_long   <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
            r_repeat <= 1'b0;
`endif

            if (press_stb_i) begin
                r_gap_cnt <= '0;
            end else if (r_gap_cnt != GAP_MAX) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (press_stb_i) begin
                        r_state   <= S_PRESS1;
                        r_stb_cnt <= STB_W'(1);
                        r_held    <= 1'b1;
                    end
                end

                S_PRESS1: begin
                    if (press_stb_i) begin
                        r_stb_cnt <= w_stb_next;
                        if (w_long_hit) begin
                            r_long  <= 1'b1;
                            r_state <= S_LONG;
`ifdef KEY_EVENT_REPEAT_EN
                            r_rep_cnt <= '0;
`endif
                        end
                    end else if (w_release) begin
                        r_state   <= S_WAIT2;
                        r_win_cnt <= '0;
                        r_held    <= 1'b0;
                    end
                end

                S_WAIT2: begin
                    if (press_stb_i) begin
                        r_state <= S_PRESS2;
                        r_held  <= 1'b1;
                    end else if (r_win_cnt == WIN_LAST) begin
                        r_click <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_win_cnt <= r_win_cnt + 1'b1;
                    end
                end

                S_PRESS2: begin
                    if (w_release) begin
                        r_double <= 1'b1;
                        r_state  <= S_IDLE;
                        r_held   <= 1'b0;
                    end
                end

                S_LONG: begin
`ifdef KEY_EVENT_REPEAT_EN
                    if (press_stb_i) begin
                        if (w_rep_next == REP_MAX) begin
                            r_repeat  <= 1'b1;
                            r_rep_cnt <= '0;
                        end else begin
                            r_rep_cnt <= w_rep_next;
                        end
                    end
`endif
                    if (w_release) begin
                        r_state <= S_IDLE;
                        r_held  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_held  <= 1'b0;
                end
            endcase
        end
    end

    assign click_o        = r_click;
    assign double_click_o = r_double;
    assign long_press_o   = r_long;
    assign held_o         = r_held;

endmodule
